// File: rtl/scan_step_pkg.sv
// Shared types and constants for the scan_step register/strobe responder.
// The optional start-abort behaviour is selected by SCAN_STEP_ABORT_EN in scan_step_regbus.
package scan_step_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] CTRL_A   = 8'h00;
   localparam logic [7:0] HPER_A   = 8'h01;
   localparam logic [7:0] STAT_A   = 8'h02;
   localparam logic [7:0] ID_A     = 8'h03;
   localparam logic [7:0] SCR_LO_A = 8'h04;
   localparam logic [7:0] SCR_HI_A = 8'h07;

   localparam int CTRL_DIR_B = 0;
   localparam int CTRL_EN_B  = 1;

   // Bit positions of the strobes inside the shared rise detector.
   localparam int N_STROBE  = 6;
   localparam int STB_AW    = 0;
   localparam int STB_SW    = 1;
   localparam int STB_SR    = 2;
   localparam int STB_CR    = 3;
   localparam int STB_SW32  = 4;
   localparam int STB_START = 5;

   function automatic logic [7:0] eff_half(input logic [7:0] hp);
      return (hp == 8'd0) ? 8'd1 : hp;
   endfunction

endpackage

// File: rtl/scan_step_edge.sv
// N-bit rising-edge detector for level strobes coming from software PIOs.
module scan_step_edge #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] i_level,
   output logic [N-1:0] o_rise
);

   logic [N-1:0] r_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_q <= '0;
      else          r_q <= i_level;
   end

   assign o_rise = i_level & ~r_q;

endmodule

// File: rtl/scan_step_regbus.sv
// Register/strobe bus responder with stepper sequencer, time counter and status word.
// Define SCAN_STEP_ABORT_EN to let a falling start_step abort a run in progress.
//
// state  | meaning
// S_IDLE | waiting for a start rise with CTRL.enable set
// S_RUN  | emitting step pulses; CTRL and step_len writes are blocked
// S_DONE | stop_step asserted until start_step returns low
module scan_step_regbus
   import scan_step_pkg::*;
#(
   parameter logic [7:0] ID_CODE         = 8'hA5,
   parameter logic [7:0] DEF_HALF_PERIOD = 8'd50
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  addr,
   input  logic [7:0]  wdata,
   input  logic        addr_write,
   input  logic        swrite,
   input  logic        sread,
   input  logic        cread,
   input  logic        swrite32,
   input  logic [31:0] wdata32,
   input  logic        start_step,
   output logic        stop_step,
   output logic [7:0]  rdata,
   output logic [31:0] rdata32,
   output logic [31:0] time_count,
   output logic [31:0] signals,
   output logic        step,
   output logic        dir
);

   logic [N_STROBE-1:0] w_strobes;
   logic [N_STROBE-1:0] w_rise;
   logic                w_start_fall;

   state_t      r_state, w_state_nx;
   logic        r_step, w_step_nx;
   logic [7:0]  r_cnt, w_cnt_nx;
   logic [31:0] r_remain, w_remain_nx;
   logic [31:0] r_pos, w_pos_nx;

   logic [7:0]  r_addr;
   logic [7:0]  r_ctrl;
   logic [7:0]  r_hper;
   logic [7:0]  r_scr [4];
   logic [31:0] r_step_len;
   logic [7:0]  r_rdata;
   logic [31:0] r_rdata32;
   logic [31:0] r_time;

   logic        w_busy, w_done;
   logic [7:0]  w_hp_m1;
   logic [7:0]  w_rd_val;

   assign w_strobes = {start_step, swrite32, cread, sread, swrite, addr_write};

   scan_step_edge #(.N(N_STROBE)) u_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .i_level (w_strobes),
      .o_rise  (w_rise)
   );

`ifdef SCAN_STEP_ABORT_EN
   scan_step_edge #(.N(1)) u_start_fall (
      .clk     (clk),
      .reset_n (reset_n),
      .i_level (~start_step),
      .o_rise  (w_start_fall)
   );
`else
   assign w_start_fall = 1'b0;
`endif

   assign w_busy  = (r_state == S_RUN);
   assign w_done  = (r_state == S_DONE);
   assign w_hp_m1 = eff_half(r_hper) - 8'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_step   <= 1'b0;
         r_cnt    <= 8'd0;
         r_remain <= 32'd0;
         r_pos    <= 32'd0;
      end else begin
         r_state  <= w_state_nx;
         r_step   <= w_step_nx;
         r_cnt    <= w_cnt_nx;
         r_remain <= w_remain_nx;
         r_pos    <= w_pos_nx;
      end
   end

   // The phase down-counter hitting zero ends a phase; a low phase ending with
   // nothing remaining closes the run, otherwise the next pulse begins.
   always_comb begin
      w_state_nx  = r_state;
      w_step_nx   = r_step;
      w_cnt_nx    = r_cnt;
      w_remain_nx = r_remain;
      w_pos_nx    = r_pos;
      unique case (r_state)
         S_IDLE: begin
            if (w_rise[STB_START] && r_ctrl[CTRL_EN_B]) begin
               w_remain_nx = r_step_len;
               w_cnt_nx    = 8'd0;
               w_step_nx   = 1'b0;
               w_state_nx  = (r_step_len == 32'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_start_fall) begin
               w_state_nx = S_DONE;
               w_step_nx  = 1'b0;
            end else if (r_cnt != 8'd0) begin
               w_cnt_nx = r_cnt - 8'd1;
            end else if (r_step) begin
               w_step_nx   = 1'b0;
               w_cnt_nx    = w_hp_m1;
               w_remain_nx = r_remain - 32'd1;
            end else if (r_remain == 32'd0) begin
               w_state_nx = S_DONE;
            end else begin
               w_step_nx = 1'b1;
               w_cnt_nx  = w_hp_m1;
               w_pos_nx  = r_ctrl[CTRL_DIR_B] ? r_pos + 32'd1 : r_pos - 32'd1;
            end
         end
         S_DONE: begin
            if (!start_step) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      w_rd_val = 8'h00;
      if (r_addr == CTRL_A)      w_rd_val = r_ctrl;
      else if (r_addr == HPER_A) w_rd_val = r_hper;
      else if (r_addr == STAT_A) w_rd_val = {5'b0, r_ctrl[CTRL_DIR_B], w_done, w_busy};
      else if (r_addr == ID_A)   w_rd_val = ID_CODE;
      else if (r_addr >= SCR_LO_A && r_addr <= SCR_HI_A) w_rd_val = r_scr[r_addr[1:0]];
   end

   // Reads and writes use the address latched before this edge, so an
   // addr_write rising together with a data strobe only affects later accesses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr     <= 8'h00;
         r_ctrl     <= 8'h00;
         r_hper     <= DEF_HALF_PERIOD;
         for (int i = 0; i < 4; i++) r_scr[i] <= 8'h00;
         r_step_len <= 32'd0;
         r_rdata    <= 8'h00;
         r_rdata32  <= 32'd0;
         r_time     <= 32'd0;
      end else begin
         r_time <= r_time + 32'd1;
         if (w_rise[STB_AW]) r_addr <= addr;
         if (w_rise[STB_SW]) begin
            if (r_addr == CTRL_A) begin
               if (!w_busy) r_ctrl <= wdata;
            end else if (r_addr == HPER_A) begin
               r_hper <= wdata;
            end else if (r_addr >= SCR_LO_A && r_addr <= SCR_HI_A) begin
               r_scr[r_addr[1:0]] <= wdata;
            end
         end
         if (w_rise[STB_SR])   r_rdata    <= w_rd_val;
         if (w_rise[STB_CR])   r_rdata32  <= r_pos;
         if (w_rise[STB_SW32] && !w_busy) r_step_len <= wdata32;
      end
   end

   assign stop_step  = w_done;
   assign step       = r_step;
   assign dir        = r_ctrl[CTRL_DIR_B];
   assign rdata      = r_rdata;
   assign rdata32    = r_rdata32;
   assign time_count = r_time;
   assign signals    = {16'h0, r_ctrl, 4'h0, dir, w_done, w_busy, r_step};

endmodule

// File: tb/tb_scan_step_regbus.sv
// Self-checking bench for scan_step_regbus; expectations come from a cycle-indexed
// behavioural model of the register map and step waveform (honours SCAN_STEP_ABORT_EN).
module tb_scan_step_regbus;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  addr, wdata;
   logic        addr_write, swrite, sread, cread, swrite32, start_step;
   logic [31:0] wdata32;
   logic        stop_step, step, dir;
   logic [7:0]  rdata;
   logic [31:0] rdata32, time_count, signals;

   always #5 clk = ~clk;

   scan_step_regbus #(.ID_CODE(8'hA5), .DEF_HALF_PERIOD(8'd50)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .addr       (addr),
      .wdata      (wdata),
      .addr_write (addr_write),
      .swrite     (swrite),
      .sread      (sread),
      .cread      (cread),
      .swrite32   (swrite32),
      .wdata32    (wdata32),
      .start_step (start_step),
      .stop_step  (stop_step),
      .rdata      (rdata),
      .rdata32    (rdata32),
      .time_count (time_count),
      .signals    (signals),
      .step       (step),
      .dir        (dir)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Clock edges seen since reset release: the reference for time_count.
   int unsigned cyc;
   always @(posedge clk or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;

   // Reference model state.
   logic [7:0]  m_ctrl, m_hp;
   logic [7:0]  m_scr [4];
   logic [31:0] m_len;
   int          m_pos;

   task automatic m_reset();
      m_ctrl = 8'h00; m_hp = 8'd50; m_len = 32'd0; m_pos = 0;
      for (int i = 0; i < 4; i++) m_scr[i] = 8'h00;
   endtask

   function automatic logic [7:0] m_read(input logic [7:0] a);
      case (a)
         8'h00: return m_ctrl;
         8'h01: return m_hp;
         8'h02: return {5'b0, m_ctrl[0], 2'b00};
         8'h03: return 8'hA5;
         8'h04, 8'h05, 8'h06, 8'h07: return m_scr[a - 8'h04];
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_addr(input logic [7:0] a);
      addr = a; addr_write = 1'b1; @(negedge clk);
      addr_write = 1'b0; @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      set_addr(a);
      wdata = d; swrite = 1'b1; @(negedge clk);
      swrite = 1'b0; @(negedge clk);
      if (a == 8'h00) m_ctrl = d;
      else if (a == 8'h01) m_hp = d;
      else if (a >= 8'h04 && a <= 8'h07) m_scr[a - 8'h04] = d;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a);
      set_addr(a);
      sread = 1'b1; @(negedge clk);
      chk(tag, 32'(rdata), 32'(m_read(a)));
      sread = 1'b0; @(negedge clk);
   endtask

   task automatic set_len(input logic [31:0] v);
      wdata32 = v; swrite32 = 1'b1; @(negedge clk);
      swrite32 = 1'b0; @(negedge clk);
      m_len = v;
   endtask

   task automatic pos_chk(input string tag);
      cread = 1'b1; @(negedge clk);
      chk(tag, rdata32, 32'(m_pos));
      cread = 1'b0; @(negedge clk);
   endtask

   function automatic int run_len(input int len, input int hp);
      return (len == 0) ? 0 : 1 + 2 * hp * len;
   endfunction

   function automatic int hp_eff();
      return (m_hp == 8'd0) ? 1 : int'(m_hp);
   endfunction

   // One start/stop handshake. Sample c is taken after edge N+c, where N is the
   // edge that sees the start rise; start is dropped for edge N+drop_c+1.
   task automatic run(input int drop_c, input bit mid_wr);
      int hp, len, t_end, endc, last, pulses;
      bit ab, e_step, e_busy, e_done;
      hp    = hp_eff();
      len   = int'(m_len);
      t_end = run_len(len, hp);
      ab    = 1'b0;
`ifdef SCAN_STEP_ABORT_EN
      if (len > 0 && drop_c + 1 < t_end) ab = 1'b1;
`endif
      endc = ab ? drop_c + 1 : t_end;
      last = (drop_c > endc) ? drop_c : endc;
      if (mid_wr) begin
         set_addr(8'h00);
         wdata = m_ctrl ^ 8'h01;
      end
      start_step = 1'b1;
      for (int c = 0; c <= last + 1; c++) begin
         @(negedge clk);
         e_step = (c >= 1) && (c < endc) && ((c - 1) / (2 * hp) < len) && ((c - 1) % (2 * hp) < hp);
         e_busy = (len > 0) && (c < endc);
         e_done = (c >= endc) && (c <= last);
         chk("run_signals", signals, {16'h0, m_ctrl, 4'h0, m_ctrl[0], e_done, e_busy, e_step});
         chk("run_step", 32'(step), 32'(e_step));
         chk("run_stop", 32'(stop_step), 32'(e_done));
         if (c == drop_c) start_step = 1'b0;
         if (mid_wr) begin
            if (c == 0) swrite = 1'b1;
            if (c == 1) begin swrite = 1'b0; wdata32 = ~m_len; swrite32 = 1'b1; end
            if (c == 2) swrite32 = 1'b0;
         end
      end
      chk("time_count", time_count, 32'(cyc));
      pulses = 0;
      for (int k = 0; k < len; k++)
         if (1 + k * 2 * hp < endc) pulses++;
      m_pos += m_ctrl[0] ? pulses : -pulses;
   endtask

   initial begin
      int len, d;
      logic [7:0] a, v;
      reset_n = 1'b0;
      addr = 8'h00; wdata = 8'h00; wdata32 = 32'd0;
      addr_write = 1'b0; swrite = 1'b0; sread = 1'b0; cread = 1'b0;
      swrite32 = 1'b0; start_step = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_rdata32", rdata32, 32'h0);
      chk("rst_time", time_count, 32'h0);
      chk("rst_stop", 32'(stop_step), 32'h0);
      chk("rst_step", 32'(step), 32'h0);
      chk("rst_dir", 32'(dir), 32'h0);
      chk("rst_signals", signals, 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("time_count", time_count, 32'(cyc));

      rd_chk("id", 8'h03);
      rd_chk("unmapped", 8'h09);
      rd_chk("hper_def", 8'h01);
      wr(8'h05, 8'h3C);
      rd_chk("scr5", 8'h05);

      // Held swrite must write once; the later wdata change must not land.
      set_addr(8'h06);
      wdata = 8'h5A; swrite = 1'b1; @(negedge clk);
      wdata = 8'hC3; repeat (9) @(negedge clk);
      swrite = 1'b0; @(negedge clk);
      m_scr[2] = 8'h5A;
      rd_chk("held_swrite", 8'h06);

      // addr_write and sread rising together read the old address.
      set_addr(8'h03);
      addr = 8'h05; addr_write = 1'b1; sread = 1'b1; @(negedge clk);
      chk("same_edge_old", 32'(rdata), 32'(m_read(8'h03)));
      addr_write = 1'b0; sread = 1'b0; @(negedge clk);
      sread = 1'b1; @(negedge clk);
      chk("same_edge_new", 32'(rdata), 32'(m_read(8'h05)));
      sread = 1'b0; @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         a = 8'($urandom_range(1, 11));
         v = 8'($urandom);
         wr(a, v);
         rd_chk("rand_reg", a);
      end

      // Start with enable clear is ignored.
      wr(8'h00, 8'h01);
      start_step = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_enable", signals, {16'h0, 8'h01, 4'h0, 4'b1000});
      end
      start_step = 1'b0; @(negedge clk);

      wr(8'h00, 8'h03);
      wr(8'h01, 8'd2);
      set_len(32'd3);
      run(run_len(3, 2) + 1, 1'b1);
      pos_chk("pos_plus3");
      rd_chk("status_idle", 8'h02);

      set_len(32'd0);
      run(2, 1'b0);
      pos_chk("pos_len0");

      // Reset in the middle of a pulse.
      rd_chk("id_before_rst", 8'h03);
      wr(8'h05, 8'h77);
      set_len(32'd4);
      wr(8'h01, 8'd3);
      start_step = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_rst_step", 32'(step), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_step", 32'(step), 32'h0);
      chk("midrst_stop", 32'(stop_step), 32'h0);
      chk("midrst_signals", signals, 32'h0);
      chk("midrst_rdata", 32'(rdata), 32'h0);
      chk("midrst_time", time_count, 32'h0);
      start_step = 1'b0;
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd_chk("hper_after_rst", 8'h01);
      rd_chk("scr_after_rst", 8'h05);
      rd_chk("ctrl_after_rst", 8'h00);
      pos_chk("pos_after_rst");

      // Two reverse runs of five; mid-run CTRL and step_len writes are dropped.
      wr(8'h00, 8'h02);
      wr(8'h01, 8'($urandom_range(1, 2)));
      set_len(32'd5);
      run(run_len(5, hp_eff()), 1'b1);
      run(run_len(5, hp_eff()) + 2, 1'b1);
      pos_chk("pos_minus10");
      chk("dir_kept", 32'(dir), 32'h0);

      for (int i = 0; i < 6; i++) begin
         wr(8'h00, {6'b0, 1'b1, 1'($urandom)});
         wr(8'h01, 8'($urandom_range(0, 3)));
         len = $urandom_range(0, 4);
         set_len(32'(len));
         d = $urandom_range(0, run_len(len, hp_eff()) + 2);
         run(d, (len > 0) && (d >= 2));
         pos_chk("pos_rand");
      end

      // Drop start early in a long run.
      wr(8'h00, 8'h03);
      wr(8'h01, 8'd2);
      set_len(32'd4);
      run(5, 1'b1);
      pos_chk("pos_drop");
      chk("time_count", time_count, 32'(cyc));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
